mult_div_unit: RTL and testbench

- Iterative multi-cycle MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers for the MIPS core.
- Sits beside the single-cycle ALU and is sequenced by the control unit: the core raises start with the funct code and stalls while busy is high.
- Also services MTHI/MTLO writes.
- One shift-add/shift-subtract datapath is shared by all four arithmetic ops under a small FSM.

---
 rtl/mult_div_unit.sv | 188 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers and MTHI/MTLO writes.
// Optional macro MDU_FAST_ZERO_EN: zero multiply operands or a zero divisor skip straight to FIX.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
    localparam int         CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   araw_q, araw_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic               done_q, done_d;

    // Request decode and operand magnitudes
    logic             is_arith, op_div, op_sgn, a_neg, b_neg, fast_zero;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_arith = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign op_div   = (op == OP_DIV) || (op == OP_DIVU);
    assign op_sgn   = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg    = op_sgn & a[WIDTH-1];
    assign b_neg    = op_sgn & b[WIDTH-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;

`ifdef MDU_FAST_ZERO_EN
    assign fast_zero = op_div ? (b == '0) : ((a == '0) || (b == '0));
`else
    assign fast_zero = 1'b0;
`endif

    // Multiply step: acc = {partial, multiplier}; add multiplicand on LSB, shift right
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: acc = {remainder, dividend}; shift left, keep difference if no borrow
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // Sign fix-up applied at the FIX edge
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_q  ? -acc_q : acc_q;
    assign quo_fix  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && is_arith) state_d = fast_zero ? S_FIX : S_RUN;
            S_RUN:   if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Datapath next state
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        araw_d   = araw_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MTHI) hi_d = a;
                    if (op == OP_MTLO) lo_d = a;
                    if (is_arith) begin
                        cnt_d    = '0;
                        is_div_d = op_div;
                        neg_d    = a_neg ^ b_neg;
                        rneg_d   = a_neg;
                        dz_d     = op_div && (b == '0);
                        araw_d   = a;
                        if (op_div) begin
                            acc_d  = {{WIDTH{1'b0}}, a_mag};
                            opnd_d = b_mag;
                        end else begin
                            acc_d  = fast_zero ? '0 : {{WIDTH{1'b0}}, b_mag};
                            opnd_d = a_mag;
                        end
                    end
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
            end
            S_FIX: begin
                done_d = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (dz_q) begin
                    hi_d = araw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            araw_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            araw_q   <= araw_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a 64-bit arithmetic reference.
module tb_mult_div_unit;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, p, q, r;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        u  = '0;
        case (f)
            OP_MULTU: u = {32'b0, x} * {32'b0, y};
            OP_MULT: begin
                p = sx * sy;
                u = p;
            end
            OP_DIVU: u = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
            OP_DIV: begin
                if (y == 0) u = {x, 32'hFFFFFFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    u = {r[31:0], q[31:0]};
                end
            end
            default: u = '0;
        endcase
        return u;
    endfunction

    function automatic int ref_lat(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        int lat;
        lat = 33;
`ifdef MDU_FAST_ZERO_EN
        if ((f == OP_MULT || f == OP_MULTU) && (x == 0 || y == 0)) lat = 1;
        if ((f == OP_DIV || f == OP_DIVU) && y == 0) lat = 1;
`endif
        return lat;
    endfunction

    // Issues one arithmetic op; returns at #1 after the completing edge (done high)
    task automatic run_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y, input bit repulse);
        logic [63:0] exp;
        int cyc, lat;
        exp = ref_op(f, x, y);
        lat = ref_lat(f, x, y);
        op = f; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom; b = $urandom; op = 6'($urandom);
        chk("done_clr", 64'(done), 64'(0));
        chk("busy_rise", 64'(busy), 64'(1));
        cyc = 0;
        while (busy && cyc < 100) begin
            if (repulse && cyc == 3) begin
                start = 1'b1; op = OP_MULTU; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            if (cyc == 5) chk("hold_hilo", {hi, lo}, {exp_hi, exp_lo});
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("latency", 64'(cyc), 64'(lat));
        chk("done", 64'(done), 64'(1));
        chk($sformatf("res op=%b a=%h b=%h", f, x, y), {hi, lo}, exp);
        {exp_hi, exp_lo} = exp;
    endtask

    initial begin
        logic [5:0]  f;
        logic [31:0] x, y;
        int cyc;

        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hilo", {hi, lo}, 64'(0));
        reset = 1'b0;
        tick();

        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(OP_MULT,  32'hFFFFFFFD, 32'h00000007, 1'b0);
        run_op(OP_DIVU,  32'd100, 32'd7, 1'b0);
        run_op(OP_DIV,   32'hFFFFFFF9, 32'd2, 1'b0);
        run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op(OP_DIVU,  32'h00001234, 32'd0, 1'b0);
        run_op(OP_DIV,   32'hFFFFFF00, 32'd0, 1'b0);
        run_op(OP_MULT,  32'd0, 32'h12345678, 1'b0);
        run_op(OP_MULTU, 32'hCAFEBABE, 32'h13579BDF, 1'b1);
        tick();
        chk("done_pulse_end", 64'(done), 64'(0));

        // MTHI / MTLO and an ignored funct
        op = OP_MTHI; a = 32'hDEADBEEF; start = 1'b1;
        tick();
        start = 1'b0;
        chk("mthi", {hi, lo}, {32'hDEADBEEF, exp_lo});
        chk("mthi_busy", {62'b0, busy, done}, 64'(0));
        exp_hi = 32'hDEADBEEF;
        op = OP_MTLO; a = 32'h0BADF00D; start = 1'b1;
        tick();
        start = 1'b0;
        chk("mtlo", {hi, lo}, {exp_hi, 32'h0BADF00D});
        chk("mtlo_busy", {62'b0, busy, done}, 64'(0));
        exp_lo = 32'h0BADF00D;
        op = 6'b100000; a = 32'h55555555; b = 32'h2; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("ign_op", {hi, lo}, {exp_hi, exp_lo});
        chk("ign_busy", {62'b0, busy, done}, 64'(0));

        // Reset mid-operation at busy cycle 10
        op = OP_MULT; a = 32'd5; b = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("pre_rst_busy", 64'(busy), 64'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_hilo", {hi, lo}, 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        exp_hi = '0; exp_lo = '0;
        cyc = 0;
        while (cyc < 40 && !done) begin
            tick();
            cyc++;
        end
        chk("no_done_after_rst", 64'(done), 64'(0));
        run_op(OP_MULT, 32'd5, 32'd6, 1'b1);

        // Random back-to-back ops
        for (int i = 0; i < 28; i++) begin
            case ($urandom_range(0, 3))
                0: f = OP_MULT;
                1: f = OP_MULTU;
                2: f = OP_DIV;
                default: f = OP_DIVU;
            endcase
            case ($urandom_range(0, 5))
                0: x = '0;
                1: x = $urandom_range(0, 1000);
                2: x = 32'h80000000;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: y = '0;
                1: y = $urandom_range(1, 20);
                2: y = 32'hFFFFFFFF;
                default: y = $urandom;
            endcase
            run_op(f, x, y, (i % 7) == 3);
        end
        tick();
        chk("final_done_clr", 64'(done), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
